dice_race_turn_fsm: RTL

- Game-logic stage directly downstream of the color detection / result-manager path.
- Consumes the stable dice color and the turn pulses, and runs a two-player race on a linear track.
- Converts each roll to a step count and advances the active player's token one step per paced interval.
- Publishes token positions, turn and winner state to the VGA overlay and LED logic.

---
 rtl/dice_race_pkg.sv | 29 ++
 rtl/dice_race_turn_fsm_step_pacer.sv | 39 +++
 rtl/dice_race_turn_fsm.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dice_race_pkg.sv
// Shared types for the dice race game: dice colors, FSM state encodings and roll-to-steps mapping.
package dice_race_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_ROLL  = 3'd1,
    ST_MOVE       = 3'd2,
    ST_WAIT_CLEAR = 3'd3,
    ST_GAME_OVER  = 3'd4
  } game_state_e;

  function automatic logic [1:0] color_to_steps(color_e color, int red_steps,
                                                int green_steps, int blue_steps);
    case (color)
      COLOR_RED:   return 2'(red_steps);
      COLOR_GREEN: return 2'(green_steps);
      COLOR_BLUE:  return 2'(blue_steps);
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dice_race_turn_fsm_step_pacer.sv
// Divides enabled frame_tick pulses by STEP_TICKS; step_pulse is combinational on the
// qualifying tick. clear wins over counting so a restart or new roll never steps.
module step_pacer #(
  parameter int STEP_TICKS = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic frame_tick,
  output logic step_pulse
);

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(STEP_TICKS - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    step_pulse = 1'b0;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable && frame_tick) begin
      if (tick_cnt_q == LAST_TICK) begin
        tick_cnt_d = '0;
        step_pulse = 1'b1;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

endmodule

// File: rtl/dice_race_turn_fsm.sv
// Two-player dice race: latches a roll, paces the token forward one square per STEP_TICKS
// frames, alternates turns once the die is cleared, and flags the first player to finish.
module dice_race_turn_fsm
  import dice_race_pkg::*;
#(
  parameter int TRACK_LEN   = 20,
  parameter int STEP_TICKS  = 30,
  parameter int RED_STEPS   = 1,
  parameter int GREEN_STEPS = 2,
  parameter int BLUE_STEPS  = 3,
  localparam int POS_W      = $clog2(TRACK_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             start_btn,
  input  logic [1:0]       stable_color,
  input  logic             result_ready,
  input  logic             turn_end,
  input  logic             current_state_white,
  output logic [POS_W-1:0] player_pos_0,
  output logic [POS_W-1:0] player_pos_1,
  output logic             current_player,
  output logic [1:0]       last_roll,
  output logic [2:0]       game_state,
  output logic             move_busy,
  output logic             winner_valid,
  output logic             winner_id
);

  localparam logic [POS_W-1:0] END_POS = POS_W'(TRACK_LEN);

  game_state_e      state_q, state_d;
  logic [POS_W-1:0] pos0_q, pos0_d, pos1_q, pos1_d, new_pos;
  logic             player_q, player_d;
  logic [1:0]       roll_q, roll_d;
  logic [1:0]       steps_q, steps_d, new_steps;
  logic             win_vld_q, win_vld_d, win_id_q, win_id_d;
  logic             pacer_clear, step_pulse;

  step_pacer #(.STEP_TICKS(STEP_TICKS)) u_pacer (
    .clk        (clk),
    .reset      (reset),
    .clear      (pacer_clear),
    .enable     (state_q == ST_MOVE),
    .frame_tick (frame_tick),
    .step_pulse (step_pulse)
  );

  always_comb begin
    state_d     = state_q;
    pos0_d      = pos0_q;
    pos1_d      = pos1_q;
    player_d    = player_q;
    roll_d      = roll_q;
    steps_d     = steps_q;
    win_vld_d   = win_vld_q;
    win_id_d    = win_id_q;
    pacer_clear = 1'b0;
    new_pos     = (player_q ? pos1_q : pos0_q) + 1'b1;
    new_steps   = steps_q - 2'd1;

    if (start_btn) begin
      state_d     = ST_WAIT_ROLL;
      pos0_d      = '0;
      pos1_d      = '0;
      player_d    = 1'b0;
      roll_d      = 2'd0;
      steps_d     = 2'd0;
      win_vld_d   = 1'b0;
      win_id_d    = 1'b0;
      pacer_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
        end
        ST_WAIT_ROLL: begin
          if (result_ready && (color_e'(stable_color) != COLOR_NONE)) begin
            roll_d      = stable_color;
            steps_d     = color_to_steps(color_e'(stable_color), RED_STEPS, GREEN_STEPS, BLUE_STEPS);
            pacer_clear = 1'b1;
            state_d     = ST_MOVE;
          end
        end
        ST_MOVE: begin
          // Reaching the finish ends the game even if squares remain on this roll.
          if (step_pulse) begin
            if (player_q) pos1_d = new_pos;
            else          pos0_d = new_pos;
            steps_d = new_steps;
            if (new_pos == END_POS) begin
              state_d   = ST_GAME_OVER;
              win_vld_d = 1'b1;
              win_id_d  = player_q;
            end else if (new_steps == 2'd0) begin
              state_d = ST_WAIT_CLEAR;
            end
          end
        end
        ST_WAIT_CLEAR: begin
          if (turn_end || current_state_white) begin
            player_d = ~player_q;
            state_d  = ST_WAIT_ROLL;
          end
        end
        ST_GAME_OVER: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos0_q    <= '0;
      pos1_q    <= '0;
      player_q  <= 1'b0;
      roll_q    <= 2'd0;
      steps_q   <= 2'd0;
      win_vld_q <= 1'b0;
      win_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos0_q    <= pos0_d;
      pos1_q    <= pos1_d;
      player_q  <= player_d;
      roll_q    <= roll_d;
      steps_q   <= steps_d;
      win_vld_q <= win_vld_d;
      win_id_q  <= win_id_d;
    end
  end

  assign player_pos_0   = pos0_q;
  assign player_pos_1   = pos1_q;
  assign current_player = player_q;
  assign last_roll      = roll_q;
  assign game_state     = state_q;
  assign move_busy      = (state_q == ST_MOVE);
  assign winner_valid   = win_vld_q;
  assign winner_id      = win_id_q;

endmodule
